cache_way_array: RTL and testbench

Parametrised storage array for one way of a direct-mapped/set-associative cache: per-index valid, dirty, tag and line data, with combinational lookup and byte-masked write-hit merging. Adds a built-in flush walker that scans every index, hands dirty lines out over a valid/ready writeback port, and optionally invalidates as it goes. It also keeps a live dirty-line count. It sits under the cache control FSM and replaces the fixed 8-entry set array.

---
 rtl/cache_way_array_if.sv | 17 +
 rtl/cache_way_array.sv | 155 +++++++++++++++
 tb/tb_cache_way_array.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_way_array_if.sv
// Writeback port of the cache way array: dirty lines offered by the flush walker.
// A line transfers on every rising edge where wb_valid && wb_ready; wb_index/tag/data
// stay stable from wb_valid rising until that edge, and wb_valid never drops without it.
interface cache_way_array_if #(
    parameter int IDX_W      = 3,
    parameter int TAG_WIDTH  = 9,
    parameter int LINE_WIDTH = 128
);
    logic                  wb_valid;
    logic                  wb_ready;
    logic [IDX_W-1:0]      wb_index;
    logic [TAG_WIDTH-1:0]  wb_tag;
    logic [LINE_WIDTH-1:0] wb_data;

    modport master (output wb_valid, wb_index, wb_tag, wb_data, input wb_ready);
    modport slave  (input wb_valid, wb_index, wb_tag, wb_data, output wb_ready);
endinterface

// File: rtl/cache_way_array.sv
// One cache way: per-index valid/dirty/tag/data with combinational lookup, byte-masked
// modify, a flush walker that writes back dirty lines, and a live dirty-line count.
module cache_way_array #(
    parameter int NUM_SETS   = 8,
    parameter int TAG_WIDTH  = 9,
    parameter int LINE_WIDTH = 128,
    parameter int IDX_W      = $clog2(NUM_SETS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [IDX_W-1:0]        rd_index,
    output logic                    out_valid,
    output logic                    out_dirty,
    output logic [TAG_WIDTH-1:0]    out_tag,
    output logic [LINE_WIDTH-1:0]   out_data,
    input  logic                    wr_en,
    input  logic                    wr_type,
    input  logic [IDX_W-1:0]        wr_index,
    input  logic [TAG_WIDTH-1:0]    wr_tag,
    input  logic [LINE_WIDTH-1:0]   wr_data,
    input  logic [LINE_WIDTH/8-1:0] wr_byte_en,
    output logic                    wr_accept,
    input  logic                    flush_req,
    input  logic                    flush_inv,
    cache_way_array_if.master       wb,
    output logic                    busy,
    output logic                    flush_done,
    output logic [IDX_W:0]          dirty_count,
    output logic [1:0]              walk_state
);
    localparam int NBYTES = LINE_WIDTH / 8;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SCAN = 2'd1, ST_DONE = 2'd2} walk_state_e;

    walk_state_e           state_q, state_d;
    logic [NUM_SETS-1:0]   valid_q, dirty_q;
    logic [TAG_WIDTH-1:0]  tag_q  [NUM_SETS];
    logic [LINE_WIDTH-1:0] data_q [NUM_SETS];
    logic [IDX_W-1:0]      scan_idx_q;
    logic                  inv_q;
    logic [IDX_W:0]        dirty_count_q;

    logic                  cur_dirty, scan_last, scan_advance, scan_start, wb_valid_c;
    logic                  fill_commit, mod_commit, cnt_inc, cnt_dec;
    logic [LINE_WIDTH-1:0] merged;

    assign out_valid   = valid_q[rd_index];
    assign out_dirty   = dirty_q[rd_index];
    assign out_tag     = tag_q[rd_index];
    assign out_data    = data_q[rd_index];
    assign wr_accept   = wr_en & ~busy;
    assign dirty_count = dirty_count_q;
    assign walk_state  = state_q;

    assign fill_commit = wr_accept & ~wr_type;
    assign mod_commit  = wr_accept & wr_type & valid_q[wr_index];
    assign cur_dirty   = valid_q[scan_idx_q] & dirty_q[scan_idx_q];
    assign scan_last   = (scan_idx_q == IDX_W'(NUM_SETS - 1));

    assign wb.wb_valid = wb_valid_c;
    assign wb.wb_index = scan_idx_q;
    assign wb.wb_tag   = tag_q[scan_idx_q];
    assign wb.wb_data  = data_q[scan_idx_q];

    always_comb begin
        merged = data_q[wr_index];
        for (int i = 0; i < NBYTES; i++) begin
            if (wr_byte_en[i]) merged[i*8 +: 8] = wr_data[i*8 +: 8];
        end
    end

    // Walker state register and next-state/output decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        busy         = 1'b0;
        flush_done   = 1'b0;
        wb_valid_c   = 1'b0;
        scan_advance = 1'b0;
        scan_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d    = ST_SCAN;
                    scan_start = 1'b1;
                end
            end
            ST_SCAN: begin
                busy         = 1'b1;
                wb_valid_c   = cur_dirty;
                scan_advance = ~cur_dirty | wb.wb_ready;
                if (scan_advance && scan_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                flush_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx_q <= '0;
            inv_q      <= 1'b0;
        end else if (scan_start) begin
            scan_idx_q <= '0;
            inv_q      <= flush_inv;
        end else if (scan_advance) begin
            scan_idx_q <= scan_idx_q + IDX_W'(1);
        end
    end

    // Writes are never accepted during SCAN, so write and walker updates never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (fill_commit) begin
                valid_q[wr_index] <= 1'b1;
                dirty_q[wr_index] <= 1'b0;
            end else if (mod_commit) begin
                dirty_q[wr_index] <= 1'b1;
            end
            if (scan_advance) begin
                dirty_q[scan_idx_q] <= 1'b0;
                if (inv_q) valid_q[scan_idx_q] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_commit) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end else if (mod_commit) begin
            data_q[wr_index] <= merged;
        end
    end

    assign cnt_inc = mod_commit & ~dirty_q[wr_index];
    assign cnt_dec = (fill_commit & valid_q[wr_index] & dirty_q[wr_index]) |
                     (scan_advance & cur_dirty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       dirty_count_q <= '0;
        else if (cnt_inc) dirty_count_q <= dirty_count_q + (IDX_W+1)'(1);
        else if (cnt_dec) dirty_count_q <= dirty_count_q - (IDX_W+1)'(1);
    end
endmodule

// File: tb/tb_cache_way_array.sv
// Directed bench for cache_way_array: lookup, fill/modify merging, dirty count,
// flush walks with and without invalidate, reset mid-walk, and flush request corner cases.
module tb_cache_way_array;
    localparam int NUM_SETS   = 8;
    localparam int TAG_WIDTH  = 9;
    localparam int LINE_WIDTH = 128;
    localparam int IDX_W      = 3;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [IDX_W-1:0]        rd_index = '0;
    logic                    out_valid, out_dirty;
    logic [TAG_WIDTH-1:0]    out_tag;
    logic [LINE_WIDTH-1:0]   out_data;
    logic                    wr_en = 1'b0, wr_type = 1'b0;
    logic [IDX_W-1:0]        wr_index = '0;
    logic [TAG_WIDTH-1:0]    wr_tag = '0;
    logic [LINE_WIDTH-1:0]   wr_data = '0;
    logic [LINE_WIDTH/8-1:0] wr_byte_en = '0;
    logic                    wr_accept;
    logic                    flush_req = 1'b0, flush_inv = 1'b0;
    logic                    busy, flush_done;
    logic [IDX_W:0]          dirty_count;
    logic [1:0]              walk_state;

    int tests = 0;
    int fails = 0;

    logic [IDX_W-1:0]      exp_idx_q[$];
    logic [TAG_WIDTH-1:0]  exp_tag_q[$];
    logic [LINE_WIDTH-1:0] exp_q[$];

    cache_way_array_if #(.IDX_W(IDX_W), .TAG_WIDTH(TAG_WIDTH), .LINE_WIDTH(LINE_WIDTH)) wb();

    cache_way_array #(.NUM_SETS(NUM_SETS), .TAG_WIDTH(TAG_WIDTH), .LINE_WIDTH(LINE_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .rd_index(rd_index),
        .out_valid(out_valid), .out_dirty(out_dirty), .out_tag(out_tag), .out_data(out_data),
        .wr_en(wr_en), .wr_type(wr_type), .wr_index(wr_index), .wr_tag(wr_tag),
        .wr_data(wr_data), .wr_byte_en(wr_byte_en), .wr_accept(wr_accept),
        .flush_req(flush_req), .flush_inv(flush_inv), .wb(wb.master),
        .busy(busy), .flush_done(flush_done), .dirty_count(dirty_count), .walk_state(walk_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [LINE_WIDTH-1:0] obs, input logic [LINE_WIDTH-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic do_write(input logic typ, input int idx, input logic [TAG_WIDTH-1:0] tag,
                            input logic [LINE_WIDTH-1:0] data, input logic [LINE_WIDTH/8-1:0] be);
        wr_en = 1'b1; wr_type = typ; wr_index = IDX_W'(idx);
        wr_tag = tag; wr_data = data; wr_byte_en = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic peek(input int idx);
        rd_index = IDX_W'(idx);
        #1;
    endtask

    task automatic expect_wb(input int idx, input logic [TAG_WIDTH-1:0] tag, input logic [LINE_WIDTH-1:0] data);
        exp_idx_q.push_back(IDX_W'(idx));
        exp_tag_q.push_back(tag);
        exp_q.push_back(data);
    endtask

    // Runs one walk for a fixed 40 cycles; cycle n is the n-th cycle after flush_req was sampled.
    task automatic run_walk(input logic inv, input int wait_idx, input int wait_cyc,
                            input logic busy_wr, input logic rep_req,
                            output int done_n, output int hs_n, output int done_pulses, output int bad_wb);
        int waited;
        waited = 0; done_n = -1; hs_n = 0; done_pulses = 0; bad_wb = 0;
        flush_req = 1'b1; flush_inv = inv;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 1) begin flush_req = 1'b0; flush_inv = 1'b0; wr_en = 1'b0; end
            if (n == 3 && busy_wr) begin
                wr_en = 1'b1; wr_type = 1'b0; wr_index = 3'd3; wr_tag = 9'h1FF; wr_data = '1;
            end
            if (n == 3 && rep_req) flush_req = 1'b1;
            if (n == 4) begin wr_en = 1'b0; flush_req = 1'b0; end
            wb.wb_ready = wb.wb_valid && !(int'(wb.wb_index) == wait_idx && waited < wait_cyc);
            if (wb.wb_valid && !wb.wb_ready) waited++;
            #1;
            if (n == 3 && busy_wr) check("busy_wr_accept", LINE_WIDTH'(wr_accept), '0);
            if (wb.wb_valid && !busy) bad_wb++;
            if (wb.wb_valid && wb.wb_ready) begin
                hs_n++;
                if (exp_idx_q.size() == 0) begin
                    check("wb_unexpected", LINE_WIDTH'(wb.wb_index), '1);
                end else begin
                    check("wb_index", LINE_WIDTH'(wb.wb_index), LINE_WIDTH'(exp_idx_q.pop_front()));
                    check("wb_tag", LINE_WIDTH'(wb.wb_tag), LINE_WIDTH'(exp_tag_q.pop_front()));
                    check("wb_data", wb.wb_data, exp_q.pop_front());
                end
            end
            if (flush_done) begin
                done_pulses++;
                if (done_n < 0) done_n = n;
            end
        end
        wb.wb_ready = 1'b0;
    endtask

    localparam logic [LINE_WIDTH-1:0] D0 = 128'h0F0E0D0C0B0A09080706050403020100;

    initial begin
        int done_n, hs_n, pulses, bad_wb, seen;
        wb.wb_ready = 1'b0;

        // Reset state
        #12;
        peek(0);
        check("rst_valid", LINE_WIDTH'(out_valid), '0);
        check("rst_busy", LINE_WIDTH'(busy), '0);
        check("rst_wb_valid", LINE_WIDTH'(wb.wb_valid), '0);
        check("rst_done", LINE_WIDTH'(flush_done), '0);
        check("rst_count", LINE_WIDTH'(dirty_count), '0);
        rst_n = 1'b1;
        tick();

        // Fill and lookup
        wr_en = 1'b1; #1;
        check("idle_accept", LINE_WIDTH'(wr_accept), 1);
        wr_en = 1'b0;
        do_write(1'b0, 3, 9'h1A5, D0, 16'hFFFF);
        peek(3);
        check("fill_valid", LINE_WIDTH'(out_valid), 1);
        check("fill_dirty", LINE_WIDTH'(out_dirty), 0);
        check("fill_tag", LINE_WIDTH'(out_tag), LINE_WIDTH'(9'h1A5));
        check("fill_data", out_data, D0);
        check("fill_count", LINE_WIDTH'(dirty_count), 0);

        // Byte-masked modify
        do_write(1'b1, 3, 9'h000, '1, 16'h0003);
        peek(3);
        check("mod_data", out_data, 128'h0F0E0D0C0B0A0908070605040302FFFF);
        check("mod_dirty", LINE_WIDTH'(out_dirty), 1);
        check("mod_tag", LINE_WIDTH'(out_tag), LINE_WIDTH'(9'h1A5));
        check("mod_count", LINE_WIDTH'(dirty_count), 1);

        // Modify of invalid line: accepted but no effect
        wr_en = 1'b1; wr_type = 1'b1; wr_index = 3'd5; wr_data = '1; wr_byte_en = 16'hFFFF; #1;
        check("inv_mod_accept", LINE_WIDTH'(wr_accept), 1);
        tick();
        wr_en = 1'b0;
        peek(5);
        check("inv_mod_valid", LINE_WIDTH'(out_valid), 0);
        check("inv_mod_count", LINE_WIDTH'(dirty_count), 1);

        // Modify of already-dirty line keeps count; fill over dirty line decrements
        do_write(1'b1, 3, 9'h000, {16{8'h11}}, 16'h8000);
        peek(3);
        check("mod2_data", out_data, 128'h110E0D0C0B0A0908070605040302FFFF);
        check("mod2_count", LINE_WIDTH'(dirty_count), 1);
        do_write(1'b0, 3, 9'h0AA, {16{8'h33}}, 16'h0000);
        peek(3);
        check("refill_dirty", LINE_WIDTH'(out_dirty), 0);
        check("refill_count", LINE_WIDTH'(dirty_count), 0);

        // Walk without invalidate; index 1 waits 3 cycles for ready
        do_write(1'b0, 1, 9'h101, 128'h1, 16'h0);
        do_write(1'b1, 1, 9'h000, {16{8'hA1}}, 16'hFFFF);
        do_write(1'b0, 6, 9'h066, 128'h6, 16'h0);
        do_write(1'b1, 6, 9'h000, {16{8'h66}}, 16'hFFFF);
        check("pre_walk1_count", LINE_WIDTH'(dirty_count), 2);
        expect_wb(1, 9'h101, {16{8'hA1}});
        expect_wb(6, 9'h066, {16{8'h66}});
        run_walk(1'b0, 1, 3, 1'b1, 1'b0, done_n, hs_n, pulses, bad_wb);
        check("walk1_done_cycle", LINE_WIDTH'(done_n), 12);
        check("walk1_handshakes", LINE_WIDTH'(hs_n), 2);
        check("walk1_done_pulses", LINE_WIDTH'(pulses), 1);
        check("walk1_wb_outside_scan", LINE_WIDTH'(bad_wb), 0);
        check("walk1_count", LINE_WIDTH'(dirty_count), 0);
        peek(1);
        check("walk1_l1_valid", LINE_WIDTH'(out_valid), 1);
        check("walk1_l1_dirty", LINE_WIDTH'(out_dirty), 0);
        peek(6);
        check("walk1_l6_valid", LINE_WIDTH'(out_valid), 1);
        check("walk1_l6_dirty", LINE_WIDTH'(out_dirty), 0);
        peek(3);
        check("walk1_dropped_wr_tag", LINE_WIDTH'(out_tag), LINE_WIDTH'(9'h0AA));
        check("walk1_dropped_wr_data", out_data, {16{8'h33}});

        // Walk with invalidate over 8 valid lines, 2 dirty
        do_write(1'b0, 0, 9'h100, {16{8'h00}}, 16'h0);
        do_write(1'b0, 2, 9'h102, {16{8'h02}}, 16'h0);
        do_write(1'b0, 4, 9'h104, {16{8'h04}}, 16'h0);
        do_write(1'b0, 5, 9'h105, {16{8'h05}}, 16'h0);
        do_write(1'b0, 7, 9'h107, {16{8'h07}}, 16'h0);
        do_write(1'b1, 2, 9'h000, {16{8'h22}}, 16'hFFFF);
        do_write(1'b1, 7, 9'h000, {16{8'h77}}, 16'hFFFF);
        check("pre_walk2_count", LINE_WIDTH'(dirty_count), 2);
        expect_wb(2, 9'h102, {16{8'h22}});
        expect_wb(7, 9'h107, {16{8'h77}});
        run_walk(1'b1, 0, 0, 1'b1, 1'b0, done_n, hs_n, pulses, bad_wb);
        check("walk2_done_cycle", LINE_WIDTH'(done_n), 9);
        check("walk2_handshakes", LINE_WIDTH'(hs_n), 2);
        check("walk2_done_pulses", LINE_WIDTH'(pulses), 1);
        check("walk2_wb_outside_scan", LINE_WIDTH'(bad_wb), 0);
        check("walk2_count", LINE_WIDTH'(dirty_count), 0);
        for (int i = 0; i < NUM_SETS; i++) begin
            peek(i);
            check($sformatf("walk2_valid_%0d", i), LINE_WIDTH'(out_valid), 0);
        end

        // Reset asserted while a writeback is pending
        do_write(1'b0, 4, 9'h044, {16{8'h44}}, 16'h0);
        do_write(1'b1, 4, 9'h000, {16{8'hEE}}, 16'h0001);
        check("pre_rst_count", LINE_WIDTH'(dirty_count), 1);
        wb.wb_ready = 1'b0;
        flush_req = 1'b1; flush_inv = 1'b0;
        seen = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            flush_req = 1'b0;
            if (wb.wb_valid) begin seen = 1; break; end
        end
        check("rst_walk_wb_seen", LINE_WIDTH'(seen), 1);
        check("rst_walk_wb_index", LINE_WIDTH'(wb.wb_index), 4);
        rst_n = 1'b0;
        peek(4);
        check("midrst_wb_valid", LINE_WIDTH'(wb.wb_valid), 0);
        check("midrst_busy", LINE_WIDTH'(busy), 0);
        check("midrst_count", LINE_WIDTH'(dirty_count), 0);
        check("midrst_valid", LINE_WIDTH'(out_valid), 0);
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (flush_done || busy) pulses++;
        end
        check("midrst_no_done", LINE_WIDTH'(pulses), 0);

        // Modify and flush_req in the same idle cycle, repeated request while busy
        do_write(1'b0, 0, 9'h011, {16{8'h5A}}, 16'h0);
        wr_en = 1'b1; wr_type = 1'b1; wr_index = 3'd0; wr_data = {16{8'hC3}}; wr_byte_en = 16'hFFFF;
        expect_wb(0, 9'h011, {16{8'hC3}});
        run_walk(1'b0, 0, 0, 1'b0, 1'b1, done_n, hs_n, pulses, bad_wb);
        check("walk3_done_cycle", LINE_WIDTH'(done_n), 9);
        check("walk3_handshakes", LINE_WIDTH'(hs_n), 1);
        check("walk3_done_pulses", LINE_WIDTH'(pulses), 1);
        check("walk3_wb_outside_scan", LINE_WIDTH'(bad_wb), 0);
        check("walk3_count", LINE_WIDTH'(dirty_count), 0);
        peek(0);
        check("walk3_l0_valid", LINE_WIDTH'(out_valid), 1);
        check("walk3_l0_dirty", LINE_WIDTH'(out_dirty), 0);
        check("walk3_l0_data", out_data, {16{8'hC3}});

        // Final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
